// File: rtl/uart_tx_fifo_sequencer.sv
// Drains the UART TX FIFO into the transmit shifter: one outstanding read at a
// time, valid/ready hand-off, programmable inter-byte gap and sequenced clears.
module uart_tx_fifo_sequencer #(
  parameter int unsigned GAP_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic [GAP_W-1:0] gap_cycles_i,
  input  logic             fifo_empty_i,
  input  logic [7:0]       fifo_data_i,
  output logic             fifo_n_re_o,
  output logic             fifo_n_clr_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] sent_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    PRESENT,
    GAP,
    FLUSH
  } state_t;

  state_t           state;
  logic             flush_pend;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_pend   <= 1'b0;
      gap_cnt      <= '0;
      fifo_n_re_o  <= 1'b1;
      fifo_n_clr_o <= 1'b1;
      tx_data_o    <= '0;
      tx_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      sent_count_o <= '0;
    end else begin
      // Strobes are asserted on entry to READ/FLUSH and released one cycle later.
      fifo_n_re_o  <= 1'b1;
      fifo_n_clr_o <= 1'b1;
      if (flush_i) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush_pend) begin
            state        <= FLUSH;
            fifo_n_clr_o <= 1'b0;
            busy_o       <= 1'b1;
          end else if (enable_i && !fifo_empty_i) begin
            state       <= READ;
            fifo_n_re_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end

        READ: begin
          state <= LATCH;
        end

        LATCH: begin
          tx_data_o  <= fifo_data_i;
          tx_valid_o <= 1'b1;
          state      <= PRESENT;
        end

        PRESENT: begin
          if (tx_ready_i) begin
            tx_valid_o   <= 1'b0;
            sent_count_o <= sent_count_o + 1'b1;
            if (gap_cycles_i == '0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              gap_cnt <= gap_cycles_i;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          // A pending flush abandons the rest of the gap.
          if (flush_pend) begin
            state        <= FLUSH;
            fifo_n_clr_o <= 1'b0;
            gap_cnt      <= '0;
          end else if (gap_cnt <= 1) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        FLUSH: begin
          // A new request landing on the clearing cycle must survive.
          flush_pend <= flush_i;
          state      <= IDLE;
          busy_o     <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
